// File: rtl/half_sub.sv
// Registered unsigned subtractor: one-cycle latency difference and borrow-out.
// Optional borrow event counter enabled by HALF_SUB_BORROW_CNT_EN.
module half_sub #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borr
`ifdef HALF_SUB_BORROW_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      borr_cnt
`endif
);

    logic [WIDTH:0]   sub_full;
    logic             borrow;
    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borr_q, borr_d;

    // Zero-extended subtract: the extra top bit is the borrow-out.
    always_comb begin
        sub_full = {1'b0, a} - {1'b0, b};
        borrow   = sub_full[WIDTH];
    end

    always_comb begin
        diff_d = diff_q;
        borr_d = borr_q;
        if (in_valid) begin
            diff_d = sub_full[WIDTH-1:0];
            borr_d = borrow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borr_q      <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            diff_q      <= diff_d;
            borr_q      <= borr_d;
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        diff      = diff_q;
        borr      = borr_q;
    end

`ifdef HALF_SUB_BORROW_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Clear has priority over a simultaneous increment; count saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (in_valid && borrow && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb borr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_sub.sv
// Self-checking bench for half_sub: WIDTH=1 and WIDTH=8 instances driven in lockstep,
// table vectors plus scoreboard-checked gap, reset and counter sequences.
module tb_half_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic       out_valid1, diff1, borr1;
    logic       out_valid8, borr8;
    logic [7:0] diff8;
`ifdef HALF_SUB_BORROW_CNT_EN
    logic        cnt_clr;
    logic [15:0] borr_cnt1, borr_cnt8;
`endif

    always #5 clk = ~clk;

    half_sub #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .diff      (diff1),
        .borr      (borr1)
`ifdef HALF_SUB_BORROW_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .borr_cnt  (borr_cnt1)
`endif
    );

    half_sub #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .diff      (diff8),
        .borr      (borr8)
`ifdef HALF_SUB_BORROW_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .borr_cnt  (borr_cnt8)
`endif
    );

    typedef struct packed {
        logic       d1;
        logic       bo1;
        logic [7:0] d8;
        logic       bo8;
    } exp_t;

    typedef struct {
        logic       a1, b1;
        logic [7:0] a8, b8;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    exp_t last;
    logic exp_v;
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    // Reference model written from the truth-table / two's-complement definitions.
    function automatic exp_t model(input logic xa1, input logic xb1,
                                   input logic [7:0] xa8, input logic [7:0] xb8);
        exp_t r;
        r.d1  = xa1 ^ xb1;
        r.bo1 = ~xa1 & xb1;
        r.d8  = xa8 + (~xb8) + 8'd1;
        r.bo8 = (xa8 < xb8);
        return r;
    endfunction

    task automatic drive(input logic v, input logic xa1, input logic xb1,
                         input logic [7:0] xa8, input logic [7:0] xb8, input exp_t e);
        @(negedge clk);
        in_valid = v;
        a1 = xa1;
        b1 = xb1;
        a8 = xa8;
        b8 = xb8;
        if (v) sb.push_back(e);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_v <= 1'b0;
            last  <= '0;
            sb.delete();
        end else begin
            exp_v <= in_valid;
        end
    end

    // Monitor: out_valid must mirror accepted input; data pops from scoreboard or holds.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("out_valid1", {31'd0, out_valid1}, {31'd0, exp_v});
            check("out_valid8", {31'd0, out_valid8}, {31'd0, exp_v});
            if (exp_v) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL scoreboard_empty: got out_valid=1, want queued entry");
                end else begin
                    last = sb.pop_front();
                end
            end
            check("diff1", {31'd0, diff1}, {31'd0, last.d1});
            check("borr1", {31'd0, borr1}, {31'd0, last.bo1});
            check("diff8", {24'd0, diff8}, {24'd0, last.d8});
            check("borr8", {31'd0, borr8}, {31'd0, last.bo8});
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid1"}, {31'd0, out_valid1}, 32'd0);
        check({tag, "_diff1"}, {31'd0, diff1}, 32'd0);
        check({tag, "_borr1"}, {31'd0, borr1}, 32'd0);
        check({tag, "_out_valid8"}, {31'd0, out_valid8}, 32'd0);
        check({tag, "_diff8"}, {24'd0, diff8}, 32'd0);
        check({tag, "_borr8"}, {31'd0, borr8}, 32'd0);
`ifdef HALF_SUB_BORROW_CNT_EN
        check({tag, "_borr_cnt1"}, {16'd0, borr_cnt1}, 32'd0);
        check({tag, "_borr_cnt8"}, {16'd0, borr_cnt8}, 32'd0);
`endif
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1'b0, 1'b0, 8'h05, 8'h03, '{1'b0, 1'b0, 8'h02, 1'b0}};
        vecs[1] = '{1'b1, 1'b0, 8'h03, 8'h05, '{1'b1, 1'b0, 8'hFE, 1'b1}};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'hFF, '{1'b1, 1'b1, 8'h01, 1'b1}};
        vecs[3] = '{1'b1, 1'b1, 8'h5A, 8'h5A, '{1'b0, 1'b0, 8'h00, 1'b0}};
        vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'h00, '{1'b0, 1'b0, 8'hFF, 1'b0}};
        vecs[5] = '{1'b1, 1'b0, 8'h80, 8'h81, '{1'b1, 1'b0, 8'hFF, 1'b1}};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
`ifdef HALF_SUB_BORROW_CNT_EN
        cnt_clr = 1'b0;
`endif
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table vectors: out_valid stays high across the run.
        foreach (vecs[i]) drive(1'b1, vecs[i].a1, vecs[i].b1, vecs[i].a8, vecs[i].b8, vecs[i].e);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, '0);
        drive(1'b0, 1'b1, 1'b1, 8'hAA, 8'h11, '0);

        // Gapped random pairs: outputs hold during idle cycles.
        for (int i = 0; i < 15; i++) begin
            logic       ra1, rb1, v;
            logic [7:0] ra8, rb8;
            ra1 = 1'($urandom);
            rb1 = 1'($urandom);
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            v   = (i % 3) != 1;
            drive(v, ra1, rb1, ra8, rb8, model(ra1, rb1, ra8, rb8));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, '0);

        // Reset between edges right after a pair was accepted: that pair is discarded.
        drive(1'b1, 1'b0, 1'b1, 8'h03, 8'h09, model(1'b0, 1'b1, 8'h03, 8'h09));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, '0);

        // Release reset with a valid pair already present: first edge accepts it.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b0; a8 = 8'h40; b8 = 8'h10;
        sb.push_back(model(1'b1, 1'b0, 8'h40, 8'h10));
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, '0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, '0);

`ifdef HALF_SUB_BORROW_CNT_EN
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h20, model(1'b0, 1'b1, 8'h10, 8'h20));
        drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h10, model(1'b1, 1'b0, 8'h20, 8'h10));
        @(posedge clk);
        #2;
        check("cnt_three1", {16'd0, borr_cnt1}, 32'd3);
        check("cnt_three8", {16'd0, borr_cnt8}, 32'd3);
        @(negedge clk);
        cnt_clr  = 1'b1;
        in_valid = 1'b1;
        a1 = 1'b0; b1 = 1'b1; a8 = 8'h00; b8 = 8'h01;
        sb.push_back(model(1'b0, 1'b1, 8'h00, 8'h01));
        @(posedge clk);
        #2;
        check("cnt_clr_wins1", {16'd0, borr_cnt1}, 32'd0);
        check("cnt_clr_wins8", {16'd0, borr_cnt8}, 32'd0);
        @(negedge clk);
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 65534; i++)
            drive(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, model(1'b0, 1'b1, 8'h00, 8'hFF));
        @(posedge clk);
        #2;
        check("cnt_fffe1", {16'd0, borr_cnt1}, 32'hFFFE);
        check("cnt_fffe8", {16'd0, borr_cnt8}, 32'hFFFE);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, model(1'b0, 1'b1, 8'h00, 8'hFF));
        @(posedge clk);
        #2;
        check("cnt_sat1", {16'd0, borr_cnt1}, 32'hFFFF);
        check("cnt_sat8", {16'd0, borr_cnt8}, 32'hFFFF);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, '0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/half_sub.md
HALF_SUB -- requirements
Module: half_sub

Interface
REQ-001 Parameter WIDTH, default 1: operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  high = a/b sampled as a new operand pair this cycle.
REQ-005 a  input  WIDTH  minuend, unsigned.
REQ-006 b  input  WIDTH  subtrahend, unsigned.
REQ-007 out_valid  output  1  high for exactly one cycle per accepted operand pair.
REQ-008 diff  output  WIDTH  registered difference.
REQ-009 borr  output  1  registered borrow-out.
REQ-010 Port order SHALL be clk, rst_n, in_valid, a, b, out_valid, diff, borr.
REQ-011 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.

Function
REQ-012 On a rising edge with in_valid=1, diff SHALL load (a - b) mod 2^WIDTH.
REQ-013 On that same edge, borr SHALL load 1 when a < b (unsigned), else 0.
REQ-014 For WIDTH=1 this gives diff = a XOR b and borr = (NOT a) AND b: 00->0/0, 10->1/0, 01->1/1, 11->0/0.
REQ-015 Latency SHALL be one cycle: out_valid=1 in the cycle after the accepting edge.
REQ-016 With in_valid=0 at an edge, out_valid SHALL go 0; diff and borr SHALL hold their last values.
REQ-017 Back-to-back in_valid SHALL be accepted every cycle with no bubbles; there is no backpressure.
REQ-018 a=b SHALL give diff=0, borr=0; a=0, b=2^WIDTH-1 SHALL give diff=1, borr=1.
REQ-019 Outputs SHALL depend only on registered state, with no combinational input-to-output path.

Reset
REQ-020 While rst_n=0, out_valid, diff and borr SHALL be 0 immediately, independent of clk.
REQ-021 An operand pair accepted on the edge before reset asserts SHALL be discarded; no out_valid after release.
REQ-022 The first edge with rst_n=1 and in_valid=1 SHALL be accepted normally.

Configuration
REQ-023 Macro HALF_SUB_BORROW_CNT_EN SHALL be the sole compile-time option.
REQ-024 When defined, the block SHALL add input cnt_clr (1 bit) and output borr_cnt (16 bits).
REQ-025 When defined, borr_cnt SHALL increment on each accepted pair with a < b.
REQ-026 When defined, borr_cnt SHALL saturate at 0xFFFF.
REQ-027 When defined, borr_cnt SHALL clear to 0 on reset and on an edge with cnt_clr=1.
REQ-028 When defined, cnt_clr SHALL win over a simultaneous increment.
REQ-029 When undefined, cnt_clr and borr_cnt SHALL be absent and behaviour SHALL be per REQ-012..022.

Verification
REQ-030 Scenario 1 (WIDTH=1): pairs (a,b)=(0,0),(1,0),(0,1),(1,1) on consecutive cycles -> diff/borr = 0/0, 1/0, 1/1, 0/0, each one cycle later, out_valid held high for 4 cycles.
REQ-031 Scenario 2 (WIDTH=8): a=0x05, b=0x03 -> diff=0x02, borr=0; a=0x03, b=0x05 -> diff=0xFE, borr=1; a=0x00, b=0xFF -> diff=0x01, borr=1.
REQ-032 Scenario 3: in_valid pulses with gaps -> out_valid mirrors in_valid delayed by one cycle; diff/borr hold during gaps.
REQ-033 Scenario 4: assert rst_n=0 mid-stream between clock edges -> outputs 0 at once; pair sampled on the prior edge produces no out_valid.
REQ-034 Scenario 5 (macro defined): 3 borrowing pairs -> borr_cnt=3; cnt_clr together with a borrowing pair -> borr_cnt=0; forced near-saturation stream -> borr_cnt stops at 0xFFFF.
